// File: rtl/rv32_pkg.sv
// Shared constants for the integer register file: default width, the zero
// register index and the clear-sequencer state encoding.
package rv32_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: stored value, overridden by same-cycle write
// data (highest-index writer wins), forced to zero for x0 or while disabled.
module regfile_rdport import rv32_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                        en_i,
  input  logic [AW-1:0]               raddr_i,
  input  logic [NWR-1:0]              we_i,
  input  logic [NWR*AW-1:0]           waddr_i,
  input  logic [NWR*XLEN-1:0]         wdata_i,
  input  logic [NREGS-1:0][XLEN-1:0]  regs_i,
  output logic [XLEN-1:0]             rdata_o
);

  // we_i arrives already masked when forwarding is off or the file is clearing.
  always_comb begin
    rdata_o = regs_i[raddr_i];
    for (int p = 0; p < NWR; p++) begin
      if (we_i[p] && (waddr_i[p*AW +: AW] == raddr_i))
        rdata_o = wdata_i[p*XLEN +: XLEN];
    end
    if (!en_i || (raddr_i == AW'(REG_ZERO)))
      rdata_o = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read forwarding and
// a post-reset clear sequencer that zeroes every register before use.
module regfile_mp import rv32_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic                 init_busy
);

  logic                       state_q;
  logic [AW-1:0]              clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0]            regs_q [1:NREGS-1];
  logic [NREGS-1:0][XLEN-1:0] regs_flat;
  logic                       wr_en;
  logic [NWR-1:0]             byp_we;

  assign wr_en     = (state_q == ST_READY) && !rst;
  assign init_busy = (state_q == ST_CLEAR) || rst;
  assign byp_we    = ((BYPASS != 0) && wr_en) ? we : '0;
  assign clr_cnt_d = clr_cnt_q + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= AW'(1);
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_d;
      if (clr_cnt_q == AW'(NREGS-1))
        state_q <= ST_READY;
    end
  end

  // Ascending port loop: the last non-blocking write, i.e. the highest port, wins.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_CLEAR)) begin
      if (clr_cnt_q != AW'(REG_ZERO))
        regs_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (waddr[p*AW +: AW] != AW'(REG_ZERO)))
          regs_q[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    regs_flat[0] = '0;
    for (int r = 1; r < NREGS; r++)
      regs_flat[r] = regs_q[r];
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_rdport #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .NWR  (NWR),
      .AW   (AW)
    ) u_rd (
      .en_i   (!init_busy),
      .raddr_i(raddr[j*AW +: AW]),
      .we_i   (byp_we),
      .waddr_i(waddr),
      .wdata_i(wdata),
      .regs_i (regs_flat),
      .rdata_o(rdata[j*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register files (forwarding on / off) share stimulus;
// expectations are queued at drive time and checked by a negedge monitor.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a;
  logic [31:0] rdata_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .init_busy(busy_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr[4:0]), .rdata(rdata_b), .init_busy(busy_b)
  );

  // kind: 0 A.rdata0, 1 A.rdata1, 2 B.rdata0, 3 A.init_busy, 4 B.init_busy
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic [31:0] e, input string t);
    exp_t x;
    x.kind = k; x.exp = e; x.tag = t;
    sbq.push_back(x);
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0:       act = rdata_a[31:0];
        1:       act = rdata_a[63:32];
        2:       act = rdata_b;
        3:       act = {31'b0, busy_a};
        default: act = {31'b0, busy_b};
      endcase
      check(e.tag, act, e.exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    we = w; waddr = {a1, a0}; wdata = {d1, d0};
  endtask

  task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
    raddr = {r1, r0};
  endtask

  int  n;
  bit  busy;

  initial begin
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;

    // Reset held two edges, then the clear sequence
    cyc();
    rd(5'd11, 5'd0);
    push(3, 1, "busy_in_rst"); push(4, 1, "busy_b_in_rst");
    push(0, 0, "rd_in_rst");   push(2, 0, "rd_b_in_rst");
    cyc();
    rst = 1'b0;
    n = 0; busy = 1'b1;
    while (busy && n < 200) begin
      @(posedge clk); n++; #1;
      busy = busy_a;
      if (n == 5) begin
        rd(5'd3, 5'd30);
        push(0, 0, "rd_during_clear"); push(1, 0, "rd1_during_clear");
      end
    end
    check("clear_len", n, 31);
    push(4, 0, "busy_b_done");
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      push(0, 0, "rd_all_p0"); push(1, 0, "rd_all_p1"); push(2, 0, "rd_all_b");
      cyc();
    end

    // Basic write/read with forwarding comparison
    wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0); rd(5'd5, 5'd0);
    push(0, 32'hDEADBEEF, "byp_w5"); push(2, 0, "nobyp_w5"); push(1, 0, "x0_rd");
    cyc();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    push(0, 32'hDEADBEEF, "rd5"); push(2, 32'hDEADBEEF, "rd5_b"); push(1, 0, "x0_rd2");
    cyc();

    // x0 protection
    wr(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0); rd(5'd0, 5'd5);
    push(0, 0, "x0_byp"); push(2, 0, "x0_byp_b"); push(1, 32'hDEADBEEF, "rd5_keep");
    cyc();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    push(0, 0, "x0_after"); push(2, 0, "x0_after_b");
    cyc();

    // Forwarding on both read ports vs stored value
    wr(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0); rd(5'd7, 5'd7);
    push(0, 32'hA5A5A5A5, "byp7_p0"); push(1, 32'hA5A5A5A5, "byp7_p1"); push(2, 0, "nobyp7");
    cyc();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    push(0, 32'hA5A5A5A5, "rd7"); push(2, 32'hA5A5A5A5, "rd7_b");
    cyc();

    // Same-address conflict: port 1 wins
    wr(2'b11, 5'd3, 32'h1111, 5'd3, 32'h2222); rd(5'd3, 5'd5);
    push(0, 32'h2222, "conf_byp"); push(1, 32'hDEADBEEF, "conf_other"); push(2, 0, "conf_nobyp");
    cyc();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    push(0, 32'h2222, "conf_rd"); push(2, 32'h2222, "conf_rd_b");
    cyc();

    // Two ports, distinct addresses
    wr(2'b11, 5'd10, 32'hAAAA, 5'd11, 32'hBBBB); rd(5'd10, 5'd11);
    push(0, 32'hAAAA, "dual_byp0"); push(1, 32'hBBBB, "dual_byp1"); push(2, 0, "dual_nobyp");
    cyc();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0); rd(5'd11, 5'd10);
    push(0, 32'hBBBB, "dual_rd11"); push(1, 32'hAAAA, "dual_rd10"); push(2, 32'hBBBB, "dual_rd11_b");
    cyc();

    // Second reset, writes ignored during clear, restart mid-clear
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(2'b01, 5'd9, 32'hFFFF, 5'd0, 32'h0); rd(5'd11, 5'd10);
    push(3, 1, "busy_clear2"); push(0, 0, "rd_stale_hidden");
    push(1, 0, "rd1_stale_hidden"); push(2, 0, "rd_b_stale_hidden");
    repeat (9) cyc();
    push(3, 1, "busy_clear10");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0; busy = 1'b1;
    while (busy && n < 200) begin
      @(posedge clk); n++; #1;
      busy = busy_a;
      if (n == 20) wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    end
    check("restart_clear_len", n, 31);
    rd(5'd9, 5'd11);
    push(0, 0, "rd9_cleared"); push(1, 0, "rd11_cleared"); push(2, 0, "rd9_cleared_b");
    push(4, 0, "busy_b_done2");
    cyc();
    rd(5'd3, 5'd5);
    push(0, 0, "rd3_cleared"); push(1, 0, "rd5_cleared");
    cyc();

    // Writes work again after the restarted clear
    wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h1234); rd(5'd9, 5'd9);
    push(0, 32'h1234, "post_byp9"); push(2, 0, "post_nobyp9");
    cyc();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    push(0, 32'h1234, "post_rd9"); push(1, 32'h1234, "post_rd9_p1"); push(2, 32'h1234, "post_rd9_b");
    cyc();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
